sub_bytes_iter: RTL and testbench

//   First AES-128 round transformation (SubBytes), upstream of shift_rows; its out1 feeds shift_rows' in.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_sbox.sv | 42 ++++
 rtl/sub_bytes_iter.sv | 103 ++++++++++
 tb/tb_sub_bytes_iter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and state-byte indexing helper.
package aes_pkg;

    localparam int NB     = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 4*col + row, i.e. the position of a byte in the 16-byte state.
    function automatic logic [3:0] byte_idx(input logic [1:0] col, input logic [1:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box (256x8 LUT). With SUB_BYTES_INV_EN defined an `inv`
// input selects the inverse table for the decrypt path.
module aes_sbox
    import aes_pkg::*;
(
`ifdef SUB_BYTES_INV_EN
    input  logic              inv,
`endif
    input  logic [BYTE_W-1:0] in,
    output logic [BYTE_W-1:0] out
);

    // NOTE: the tables are constants feeding pure logic, not storage, so there is nothing to reset.
    localparam logic [0:255][7:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SUB_BYTES_INV_EN
    localparam logic [0:255][7:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    assign out = inv ? INV[in] : FWD[in];
`else
    assign out = FWD[in];
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Optional SUB_BYTES_INV_EN adds an `inv` input selecting the inverse S-box.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SUB_BYTES_INV_EN
    input  logic         inv,
`endif
    input  logic [127:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out1,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int         LANES    = NB * COLS_PER_CYCLE;
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(NB - COLS_PER_CYCLE);

    state_t            state;
    logic [1:0]        col_cnt;
    logic [0:15][7:0]  work;
`ifdef SUB_BYTES_INV_EN
    logic              inv_q;
`endif

    logic [3:0]        lane_idx [LANES];
    logic [7:0]        sb_in    [LANES];
    logic [7:0]        sb_out   [LANES];

    // Lane k handles row k%4 of column col_cnt + k/4.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = byte_idx(col_cnt + 2'(k / NB), 2'(k % NB));
            sb_in[k]    = work[lane_idx[k]];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_sbox
        aes_sbox u_sbox (
`ifdef SUB_BYTES_INV_EN
            .inv (inv_q),
`endif
            .in  (sb_in[k]),
            .out (sb_out[k])
        );
    end

    // out_valid trails entry into DONE by one edge, so a handshake needs out_valid already high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            col_cnt   <= 2'd0;
            work      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef SUB_BYTES_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= in;
                        col_cnt  <= 2'd0;
                        in_ready <= 1'b0;
                        state    <= ST_BUSY;
`ifdef SUB_BYTES_INV_EN
                        inv_q    <= inv;
`endif
                    end
                end
                ST_BUSY: begin
                    for (int k = 0; k < LANES; k++) begin
                        work[lane_idx[k]] <= sb_out[k];
                    end
                    col_cnt <= col_cnt + COL_STEP;
                    if (col_cnt == LAST_COL) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out1 = work;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: fixed vectors, corner sequences and a
// randomized handshake run against a GF(2^8)-derived S-box reference.
module tb_sub_bytes_iter;

    parameter int TB_COLS = 1;
    localparam int NCYC = 4 / TB_COLS;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out1;
    logic         out_valid;
    logic         out_ready;
`ifdef SUB_BYTES_INV_EN
    logic         inv;
`endif

    always #5 clk = ~clk;

    sub_bytes_iter #(.COLS_PER_CYCLE(TB_COLS)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SUB_BYTES_INV_EN
        .inv       (inv),
`endif
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1      (out1),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
        string        name;
    } vec_t;

    vec_t vecs[$];

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
            fwd_tab[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s, input logic use_inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = use_inv ? inv_tab[s[127-8*i -: 8]] : fwd_tab[s[127-8*i -: 8]];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inv(input logic v);
`ifdef SUB_BYTES_INV_EN
        inv = v;
`endif
    endtask

    // One full transaction: accept, measure latency, compare, handshake out.
    task automatic run_block(input logic [127:0] data, input logic inv_sel,
                             input logic [127:0] exp, input string name);
        int n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        check({name, " in_ready"}, 128'(in_ready), 128'(1));
        in = data;
        set_inv(inv_sel);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in = ~data;
        set_inv(~inv_sel);
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check({name, " latency"}, 128'(n), 128'(NCYC + 1));
        check({name, " data"}, out1, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, " handshake"}, 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        build_tables();

        vecs.push_back('{FIPS_IN, FIPS_OUT, "fips"});
        vecs.push_back('{{16{8'h00}}, {16{8'h63}}, "all_00"});
        vecs.push_back('{{16{8'hff}}, {16{8'h16}}, "all_ff"});
        for (int p = 0; p < 16; p++) begin
            vec_t v;
            v.din = '0;
            v.exp = {16{8'h63}};
            v.din[127-8*p -: 8] = 8'h53;
            v.exp[127-8*p -: 8] = 8'hed;
            v.name = $sformatf("byte53_pos%0d", p);
            vecs.push_back(v);
        end

        rst = 1'b1; in = '0; in_valid = 1'b0; out_ready = 1'b0;
        set_inv(1'b0);
        step(); step();
        check("reset_out1", out1, 128'h0);
        check("reset_flags", 128'({out_valid, in_ready}), 128'(2'b01));
        rst = 1'b0;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            run_block(vecs[i].din, 1'b0, vecs[i].exp, vecs[i].name);
        end

`ifdef SUB_BYTES_INV_EN
        run_block(FIPS_OUT, 1'b1, FIPS_IN, "inv_fips");
`endif

        // Back-pressure: hold DONE for 10 cycles while a second block is offered.
        begin
            int n = 0;
            logic stable = 1'b1;
            while (!in_ready && n < 20) begin step(); n++; end
            in = FIPS_IN; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 20) begin step(); n++; end
            check("bp_reach_done", 128'(out_valid), 128'(1));
            in = {16{8'h00}}; in_valid = 1'b1;
            for (int c = 0; c < 10; c++) begin
                if (out1 !== FIPS_OUT || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
                step();
            end
            check("bp_stable", 128'(stable), 128'(1));
            check("bp_out1_kept", out1, FIPS_OUT);
            in_valid = 1'b0; out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check("bp_release", 128'({out_valid, in_ready}), 128'(2'b01));
        end

        // Reset in the second BUSY cycle discards the block.
        begin
            logic seen = 1'b0;
            in = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            check("midrst_out1", out1, 128'h0);
            check("midrst_flags", 128'({out_valid, in_ready}), 128'(2'b01));
            for (int c = 0; c < 8; c++) begin
                if (out_valid) seen = 1'b1;
                step();
            end
            check("midrst_no_emit", 128'(seen), 128'(0));
            run_block(FIPS_IN, 1'b0, FIPS_OUT, "after_rst");
        end

        // Randomized traffic against the scoreboard.
        begin
            logic [127:0] exp_q[$];
            logic [127:0] pd = '0;
            logic         pinv = 1'b0;
            logic         pending = 1'b0;
            logic         acc;
            int sent = 0, got = 0, cyc = 0;
            while (got < 50 && cyc < 4000) begin
                if (!pending && sent < 50 && ($urandom % 2) == 1) begin
                    pending = 1'b1;
                    pd = {$urandom, $urandom, $urandom, $urandom};
`ifdef SUB_BYTES_INV_EN
                    pinv = 1'($urandom % 2);
`endif
                end
                in_valid = pending;
                in = pending ? pd : {$urandom, $urandom, $urandom, $urandom};
                set_inv(pinv);
                out_ready = 1'($urandom % 2);
                acc = in_valid && in_ready;
                if (acc) exp_q.push_back(ref_sub(pd, pinv));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_extra: got unexpected output %h, expected none", out1);
                    end else begin
                        check($sformatf("rand_blk%0d", got), out1, exp_q.pop_front());
                    end
                    got++;
                end
                step();
                cyc++;
                if (acc) begin
                    pending = 1'b0;
                    sent++;
                end
            end
            in_valid = 1'b0; out_ready = 1'b0;
            check("rand_count", 128'(got), 128'(50));
            check("rand_leftover", 128'(exp_q.size()), 128'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
